// File: rtl/sc_neuron_eval_ctrl.sv
// rtl/sc_neuron_eval_ctrl.sv - evaluation-window sequencer for the SC APC neuron and its SNGs
//
// Purpose: on an accepted start, clears the neuron FSM and loads SNG seeds (CLEAR),
// runs warm_q cycles with the neuron output discarded (WARMUP), then counts neuron
// output ones for len_q cycles (RUN) and offers the unipolar count and bipolar value
// through a valid/ready handshake (DONE).
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   start, len, warm   evaluation request; len/warm latched when start is accepted in IDLE
//   abort              synchronous abort back to IDLE from any non-IDLE state
//   neuron_dout        neuron output bit, counted during RUN only
//   neu_clr, sng_load  one-cycle clear/seed-load strobes (CLEAR)
//   sng_en             advance SNGs (WARMUP and RUN)
//   busy               high in every state except IDLE
//   result_valid/ready result handshake (DONE)
//   result             count of ones seen in RUN
//   result_bip         signed 2*result - len_q
module sc_neuron_eval_ctrl #(
  parameter int LEN_W  = 8,
  parameter int WARM_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [WARM_W-1:0]       warm,
  input  logic                    abort,
  input  logic                    neuron_dout,
  output logic                    neu_clr,
  output logic                    sng_load,
  output logic                    sng_en,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [LEN_W-1:0]        result,
  output logic signed [LEN_W:0]   result_bip
);

  localparam int CNT_W = (LEN_W > WARM_W) ? LEN_W : WARM_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [WARM_W-1:0]   warm_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    ones_q;
  logic                last_warm;
  logic                last_run;

  // cnt_q restarts at 0 on entry to WARMUP and RUN, so the phase ends when it reaches length-1.
  assign last_warm = (cnt_q == CNT_W'(warm_q) - CNT_W'(1));
  assign last_run  = (cnt_q == CNT_W'(len_q) - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (warm_q != '0)     state_d = S_WARMUP;
        else if (len_q != '0) state_d = S_RUN;
        else                  state_d = S_DONE;
      end
      S_WARMUP: begin
        if (last_warm) state_d = (len_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (last_run) state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      warm_q <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      // len_q is cleared too so that result_bip reads 0 after an abort.
      len_q  <= '0;
      warm_q <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q  <= len;
            warm_q <= warm;
          end
        end
        S_CLEAR: begin
          cnt_q  <= '0;
          ones_q <= '0;
        end
        S_WARMUP: begin
          cnt_q <= (state_d != S_WARMUP) ? '0 : cnt_q + CNT_W'(1);
        end
        S_RUN: begin
          cnt_q  <= (state_d != S_RUN) ? '0 : cnt_q + CNT_W'(1);
          ones_q <= ones_q + LEN_W'(neuron_dout);
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs decode the registered state only.
  assign neu_clr      = (state_q == S_CLEAR);
  assign sng_load     = (state_q == S_CLEAR);
  assign sng_en       = (state_q == S_WARMUP) || (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);

  // Computed modulo 2**(LEN_W+1); the true value lies in -len_q..+len_q so it always fits.
  assign result     = ones_q;
  assign result_bip = signed'(({1'b0, ones_q} << 1) - {1'b0, len_q});

endmodule

// File: tb/tb_sc_neuron_eval_ctrl.sv
// tb/tb_sc_neuron_eval_ctrl.sv - scoreboard testbench for sc_neuron_eval_ctrl
module tb_sc_neuron_eval_ctrl;
  localparam int LEN_W  = 8;
  localparam int WARM_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic [WARM_W-1:0]     warm;
  logic                  abort;
  logic                  neuron_dout;
  logic                  neu_clr;
  logic                  sng_load;
  logic                  sng_en;
  logic                  busy;
  logic                  result_valid;
  logic                  result_ready;
  logic [LEN_W-1:0]      result;
  logic signed [LEN_W:0] result_bip;

  typedef struct {
    int res;
    int bip;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [255:0] run_mask;

  always #5 clk = ~clk;

  sc_neuron_eval_ctrl #(.LEN_W(LEN_W), .WARM_W(WARM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .warm(warm),
    .abort(abort), .neuron_dout(neuron_dout), .neu_clr(neu_clr),
    .sng_load(sng_load), .sng_en(sng_en), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_bip(result_bip)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sng_en"}, sng_en, 0);
    check({tag, "_neu_clr"}, neu_clr, 0);
    check({tag, "_sng_load"}, sng_load, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_bip"}, result_bip, 0);
  endtask

  // mode: 0 dout=0, 1 dout=1, 2 random, 3 run_mask indexed by RUN cycle.
  // abort_at: 1-based RUN cycle on which abort is raised (0 = never).
  // poke: pulse start during RUN (must be ignored).
  task automatic do_run(input int w, input int l, input int mode, input int abort_at,
                        input int poke, input int ready_wait);
    int   n, ones, clr_cnt, load_cnt, en_cnt, run_idx, stable;
    logic d;
    logic [LEN_W-1:0] hold;
    exp_t e;
    n = 0; ones = 0; clr_cnt = 0; load_cnt = 0; en_cnt = 0; stable = 0;
    tick();
    warm  = WARM_W'(w);
    len   = LEN_W'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
    warm  = WARM_W'($urandom);
    while (!result_valid && n < 600) begin
      clr_cnt  += int'(neu_clr);
      load_cnt += int'(sng_load);
      en_cnt   += int'(sng_en);
      run_idx = n - w - 1;
      case (mode)
        0:       d = 1'b0;
        1:       d = 1'b1;
        2:       d = 1'($urandom_range(0, 1));
        default: d = (run_idx >= 0 && run_idx < 256) ? run_mask[run_idx] : 1'($urandom_range(0, 1));
      endcase
      neuron_dout = d;
      if (run_idx >= 0 && run_idx < l) ones += int'(d);
      if (n == w + l) sb_q.push_back('{ones, 2 * ones - l});
      start = (poke != 0 && run_idx == 1);
      if (poke != 0 && run_idx == 2) len = ~len;
      if (abort_at > 0 && run_idx == abort_at - 1) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        check("abort_sb_empty", sb_q.size(), 0);
        return;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("valid_seen", result_valid, 1);
    check("latency", n, w + l + 1);
    check("neu_clr_cycles", clr_cnt, 1);
    check("sng_load_cycles", load_cnt, 1);
    check("sng_en_cycles", en_cnt, w + l);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("result", result, e.res);
      check("result_bip", result_bip, e.bip);
    end
    hold = result;
    for (int i = 0; i < ready_wait; i++) begin
      tick();
      if (result_valid && result == hold && sng_en == 1'b0) stable++;
    end
    check("hold_stable", stable, ready_wait);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("post_ready_valid", result_valid, 0);
    check("post_ready_busy", busy, 0);
    check("post_ready_result", result, hold);
  endtask

  task automatic reset_mid_warmup();
    tick();
    warm  = 4'd8;
    len   = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("warmup_sng_en", sng_en, 1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    tick();
    reset = 1'b1;
    tick();
    check("after_reset_busy", busy, 0);
  endtask

  initial begin
    int idle_ok;
    reset = 1'b0; start = 1'b0; len = '0; warm = '0; abort = 1'b0;
    neuron_dout = 1'b0; result_ready = 1'b0;
    run_mask = 256'b0110101101;
    repeat (3) tick();
    check_idle_outputs("in_reset");
    reset = 1'b1;
    idle_ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy && !sng_en && !result_valid && !neu_clr) idle_ok++;
    end
    check("idle_10_cycles", idle_ok, 10);

    do_run(2, 10, 3, 0, 0, 0);
    do_run(2, 10, 3, 0, 0, 5);
    do_run(0, 0, 0, 0, 0, 1);
    do_run(0, 255, 1, 0, 0, 0);
    do_run(0, 255, 0, 0, 0, 0);
    do_run(3, 20, 2, 4, 0, 0);
    do_run(1, 7, 2, 0, 0, 2);
    do_run(5, 30, 2, 0, 1, 0);
    reset_mid_warmup();
    do_run(15, 40, 2, 0, 0, 1);
    do_run(4, 0, 2, 0, 0, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
